mem_stage_lat: RTL
==================

Name: mem_stage_lat

Overview:
- Parametrised pipeline MEMORY stage and M/W pipeline register, successor of the single-cycle word-only data-memory stage.
- Adds configurable word width (32/64), byte/half/word/double accesses with sign/zero-extended loads and byte-lane stores, misalignment detection, and a multi-cycle memory latency with a stall handshake to the hazard unit.
- Sits between execute and writeback.

Parameters:
- WORD, 32, datapath width; legal values 32 or 64.
- REG_SIZE, 5, register index width.
- DMEM_POWER, 18, log2 of RAM depth in words.
- MEM_LATENCY, 1, cycles a memory op occupies M; legal values 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  global pipeline enable; 0 freezes the stage.
- writeDataM  in  WORD  store data, right-aligned.
- ALUResultM  in  WORD  byte address / ALU result.
- pcM  in  WORD  instruction PC.
- writeRegM  in  REG_SIZE  destination register.
- regWriteM, memWriteM, mem2regM  in  1 each  control bits.
- memSizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- memUnsignedM  in  1  loads: 1 zero-extend, 0 sign-extend.
- zeroM, branchM  in  1 each  branch resolution inputs.
- finishM, validM  in  1 each  finish flag; instruction valid.
- readDataW, ALUResultW, pcW, writeDataW  out  WORD  registered to W.
- writeRegW  out  REG_SIZE  registered destination register.
- regWriteW, mem2regW, memWriteW, finishW, validW  out  1 each  registered control bits.
- misalignW  out  1  registered access-fault flag.
- PCSrcM  out  1  combinational branch-taken signal.
- stallM  out  1  combinational; asks upstream stages to hold.

Behaviour:
- Reset (reset=0 at posedge): every W output is 0, including misalignW. FSM goes to IDLE and the counter clears. RAM contents are not reset.
- RAM index = ALUResultM[DMEM_POWER+log2(WORD/8)-1 : log2(WORD/8)]. Higher address bits are ignored, so the address wraps.
- Little-endian byte lanes. Lane offset = ALUResultM[log2(WORD/8)-1:0].
- Fault conditions:
  - Access size larger than WORD (size 11 when WORD=32).
  - Offset not a multiple of the access size.
- Faulting access:
  - No RAM write; readData = 0.
  - Completes in 1 cycle with no stall.
  - misalignW=1 and validW=validM; the instruction is not dropped.
- Stores write only the selected lanes with the low bytes of writeDataM. Other lanes are unchanged.
- Loads extract the selected lanes and sign- or zero-extend to WORD (per memUnsignedM). A full-WORD access ignores memUnsignedM.
- Memory op = validM & (mem2regM | memWriteM) & no fault.
- FSM states:
  - IDLE, memory op present and MEM_LATENCY>1: stallM=1. On the edge, go to BUSY with cnt = MEM_LATENCY-2.
  - BUSY, cnt != 0: stallM=1; cnt decrements.
  - BUSY, cnt == 0: stallM=0. This is the completion cycle; go to IDLE.
  - MEM_LATENCY=1 or non-memory op: stallM=0 and no state change.
- Total: stallM is high for exactly MEM_LATENCY-1 cycles per memory op.
- RAM write happens only on the completion edge (final cycle), exactly once. Read data is sampled combinationally in the completion cycle.
- While stallM=1, the W register loads a bubble: all control outputs and misalignW 0, data outputs 0. Upstream must hold M inputs stable during the stall.
- en=0: the W register, FSM state and cnt all hold, and no RAM write occurs. stallM still reflects the current state.
- en=1 and not stalled: W captures {readData, ALUResultM, writeRegM, regWriteM, mem2regM, memWriteM, finishM, validM, pcM, writeDataM, fault}.
- PCSrcM = zeroM & branchM. It is purely combinational and independent of stall and en.
- Reset asserted mid-BUSY: returns to IDLE and clears W. A pending store is abandoned with no write.

Test Plan:
- WORD=32, LAT=1: sw 0xDEADBEEF @0x100, then lw @0x100 -> readDataW=0xDEADBEEF one cycle after lw enters M; stallM never 1.
- sb 0x80 @0x101 over 0xDEADBEEF, then lw @0x100 -> 0xDEAD80EF. lb @0x101 -> 0xFFFFFF80; lbu @0x101 -> 0x00000080.
- Misaligned ops:
  - sh @0x103 -> RAM unchanged, misalignW=1, validW=1, no stall.
  - lw @0x102 -> readDataW=0, misalignW=1.
- LAT=3: lw @0x100 -> stallM high for exactly 2 cycles, W shows bubbles (regWriteW=0) for 2 cycles, then readDataW valid. A following ALU op is not stalled.
- LAT=3, en dropped for 2 cycles mid-BUSY -> stall total extends by 2 cycles and W outputs hold. sw with reset asserted mid-BUSY -> memory unchanged, all W outputs 0.
- WORD=64: sd 0x0123456789ABCDEF @0x8, then lwu @0xC -> 0x0000000001234567; lh @0xE -> 0x0000000000000123. memSize=11 with WORD=32 -> misalignW=1.

Source files
------------

// File: rtl/mem_stage_lat.sv
// mem_stage_lat: memory stage plus M/W register. Sized loads and stores
// with fault detection, and a multi-cycle memory latency with a stall.
//
// Ports:
//   clk, reset (sync, active-low), en (pipeline enable)
//   M side: writeDataM, ALUResultM, pcM, writeRegM, regWriteM, memWriteM,
//           mem2regM, memSizeM, memUnsignedM, zeroM, branchM, finishM, validM
//   W side: readDataW, ALUResultW, pcW, writeDataW, writeRegW, regWriteW,
//           mem2regW, memWriteW, finishW, validW, misalignW (registered)
//   PCSrcM, stallM (combinational)
module mem_stage_lat #(
  parameter int WORD        = 32,
  parameter int REG_SIZE    = 5,
  parameter int DMEM_POWER  = 18,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [WORD-1:0]     writeDataM,
  input  logic [WORD-1:0]     ALUResultM,
  input  logic [WORD-1:0]     pcM,
  input  logic [REG_SIZE-1:0] writeRegM,
  input  logic                regWriteM,
  input  logic                memWriteM,
  input  logic                mem2regM,
  input  logic [1:0]          memSizeM,
  input  logic                memUnsignedM,
  input  logic                zeroM,
  input  logic                branchM,
  input  logic                finishM,
  input  logic                validM,
  output logic [WORD-1:0]     readDataW,
  output logic [WORD-1:0]     ALUResultW,
  output logic [WORD-1:0]     pcW,
  output logic [WORD-1:0]     writeDataW,
  output logic [REG_SIZE-1:0] writeRegW,
  output logic                regWriteW,
  output logic                mem2regW,
  output logic                memWriteW,
  output logic                finishW,
  output logic                validW,
  output logic                misalignW,
  output logic                PCSrcM,
  output logic                stallM
);

  localparam int NB   = WORD / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic MULTI = (MEM_LATENCY > 1);
  localparam logic [3:0] CNT_INIT =
    (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;
  localparam logic [WORD-1:0] ONES = '1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [WORD-1:0] ram_q [0:(2**DMEM_POWER)-1];

  logic [DMEM_POWER-1:0] idx;
  logic [OFFW-1:0] off, amask;
  logic [3:0] nbytes;
  logic [6:0] nbits;
  logic is_acc, fault, mem_op, done, wr_en, sgn;
  logic [WORD-1:0] sh, keep, ld, rdata, wsh;
  logic [NB-1:0] be;

  assign idx    = ALUResultM[DMEM_POWER+OFFW-1:OFFW];
  assign off    = ALUResultM[OFFW-1:0];
  assign nbytes = 4'd1 << memSizeM;
  assign nbits  = {nbytes, 3'b000};
  assign amask  = OFFW'(nbytes - 4'd1);

  assign is_acc = validM & (mem2regM | memWriteM);
  assign fault  = is_acc & ((nbytes > 4'(NB)) | (|(off & amask)));
  assign mem_op = is_acc & ~fault;

  assign PCSrcM = zeroM & branchM;

  // Load path: shift the addressed lanes down, then mask and extend.
  assign sh = ram_q[idx] >> {off, 3'b000};

  always_comb begin
    unique case (memSizeM)
      2'b00:   sgn = sh[7];
      2'b01:   sgn = sh[15];
      2'b10:   sgn = sh[31];
      default: sgn = sh[WORD-1];
    endcase
    keep  = (nbits >= 7'(WORD)) ? ONES : ~(ONES << nbits);
    ld    = (sh & keep) | ({WORD{sgn & ~memUnsignedM}} & ~keep);
    rdata = fault ? '0 : ld;
  end

  // Store path: lanes in the aligned group selected by the offset.
  assign wsh = writeDataM << {off, 3'b000};

  always_comb begin
    be = '0;
    for (int b = 0; b < NB; b++)
      be[b] = ((OFFW'(b) & ~amask) == off);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (en) begin
      unique case (state_q)
        IDLE: if (mem_op && MULTI) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
        BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
              else state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stallM = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stallM = mem_op & MULTI;
        done   = ~MULTI;
      end
      BUSY: begin
        stallM = (cnt_q != 4'd0);
        done   = (cnt_q == 4'd0);
      end
      default: ;
    endcase
  end

  // The single write lands on the completion edge only.
  assign wr_en = reset & en & memWriteM & mem_op & done;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) ram_q[idx][8*b +: 8] <= wsh[8*b +: 8];
    end
  end

  // Reset and stall bubbles both clear the whole W bundle.
  always_ff @(posedge clk) begin
    if (!reset || (en && stallM)) begin
      readDataW  <= '0;
      ALUResultW <= '0;
      pcW        <= '0;
      writeDataW <= '0;
      writeRegW  <= '0;
      regWriteW  <= 1'b0;
      mem2regW   <= 1'b0;
      memWriteW  <= 1'b0;
      finishW    <= 1'b0;
      validW     <= 1'b0;
      misalignW  <= 1'b0;
    end else if (en) begin
      readDataW  <= rdata;
      ALUResultW <= ALUResultM;
      pcW        <= pcM;
      writeDataW <= writeDataM;
      writeRegW  <= writeRegM;
      regWriteW  <= regWriteM;
      mem2regW   <= mem2regM;
      memWriteW  <= memWriteM;
      finishW    <= finishM;
      validW     <= validM;
      misalignW  <= fault;
    end
  end

endmodule
